fetch_stage_pipelined: RTL and testbench

Parametrised instruction-fetch stage: PC register, branch/redirect selection, next-PC adder, and a fixed 1-cycle synchronous instruction-memory interface.
Generalised in address/instruction width, PC step and reset vector.
Adds a valid/ready output toward decode, a small output FIFO so decode back-pressure is absorbed without losing fetched words, and redirect-driven flushing of in-flight fetches.
Sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_pipelined_fetch_out_fifo.sv | 55 +++++
 rtl/fetch_stage_pipelined.sv | 98 +++++++++
 tb/tb_fetch_stage_pipelined.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the fetch-entry record for the instruction-fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 48;
  localparam int DEF_INSTR_W = 48;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_ADDR_W-1:0]  pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_pipelined_fetch_out_fifo.sv
// Small synchronous FIFO holding fetched entries until decode accepts them.
module fetch_out_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  entry_t                         push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output entry_t                         head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Flush wins over push/pop so a redirect leaves the queue empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage_pipelined.sv
// Instruction-fetch stage: PC register, redirect handling, 1-cycle imem
// interface and an output FIFO that absorbs decode back-pressure.
module fetch_stage_pipelined
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter int unsigned       PC_STEP    = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupied;
  logic [CNT_W:0]    limit;
  logic              handshake;
  logic              issue;
  logic              push;
  entry_t            push_entry;
  entry_t            head;

  // An in-flight fetch already owns a FIFO slot; a same-cycle pop frees one
  always_comb begin
    handshake          = out_valid & out_ready;
    occupied           = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    limit              = DEPTH_C + {{CNT_W{1'b0}}, handshake};
    issue              = rst & ~redirect_valid & (occupied < limit);
    push               = inflight & ~redirect_valid;
    push_entry.instr   = imem_rdata;
    push_entry.pc      = req_pc_q;
    push_entry.pc_next = req_pc_q + STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_pc_q <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      req_pc_q <= pc;
      inflight <= 1'b1;
      pc       <= pc + STEP;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_out_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (handshake),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc;
  assign out_valid   = (count != '0);
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_pc_next = head.pc_next;

endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// Bench for fetch_stage_pipelined: queue-level reference model on a 16-bit
// instance plus directed literal checks, and an 8-bit instance for PC wrap.
module tb_fetch_stage_pipelined;

  localparam int AW = 16;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RST_PC_A = 16'h0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          redirect_a = 1'b0;
  logic [AW-1:0] rpc_a      = '0;
  logic          ready_a    = 1'b1;
  logic          req_a;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] rdata_a    = '0;
  logic          valid_a;
  logic [AW-1:0] instr_a;
  logic [AW-1:0] pc_a;
  logic [AW-1:0] pcn_a;

  logic       req_b;
  logic [7:0] addr_b;
  logic [7:0] rdata_b = '0;
  logic       valid_b;
  logic [7:0] instr_b;
  logic [7:0] pc_b;
  logic [7:0] pcn_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_stage_pipelined #(
    .ADDR_W(AW), .INSTR_W(AW), .PC_STEP(1), .RESET_PC(RST_PC_A), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_a), .redirect_pc(rpc_a),
    .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .out_valid(valid_a), .out_ready(ready_a),
    .out_instr(instr_a), .out_pc(pc_a), .out_pc_next(pcn_a)
  );

  fetch_stage_pipelined #(
    .ADDR_W(8), .INSTR_W(8), .PC_STEP(1), .RESET_PC(8'hFE), .FIFO_DEPTH(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .out_valid(valid_b), .out_ready(1'b1),
    .out_instr(instr_b), .out_pc(pc_b), .out_pc_next(pcn_b)
  );

  // Instruction memories: word = address ^ 0xA5, garbage when not requested
  always @(posedge clk) begin
    rdata_a <= req_a ? (addr_a ^ 16'h00A5) : 16'hDEAD;
    rdata_b <= req_b ? (addr_b ^ 8'hA5) : 8'hEE;
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    redirect_a = rv;
    rpc_a      = rpc;
    ready_a    = rdy;
  endtask

  // Reference model: mq holds every fetched-but-unconsumed PC, the newest of
  // which is still in flight when m_inflight is set.
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_pc = RST_PC_A;
  bit            m_inflight = 1'b0;
  bit            m_rst_pending = 1'b0;
  logic [AW-1:0] consumed[$];
  logic [7:0]    b_pc[$];
  logic [7:0]    b_pcn[$];
  logic [7:0]    b_instr[$];

  always @(negedge rst) m_rst_pending = 1'b1;

  always @(negedge clk) begin : compare
    bit ev, hs, er;
    if (!rst || m_rst_pending) begin
      mq.delete();
      m_pc          = RST_PC_A;
      m_inflight    = 1'b0;
      m_rst_pending = 1'b0;
    end
    if (!rst) begin
      check_output("rst_imem_req",    64'(req_a),   64'd0);
      check_output("rst_imem_addr",   64'(addr_a),  64'(RST_PC_A));
      check_output("rst_out_valid",   64'(valid_a), 64'd0);
      check_output("rst_out_pc",      64'(pc_a),    64'd0);
      check_output("rst_out_pc_next", 64'(pcn_a),   64'd0);
      check_output("rst_out_instr",   64'(instr_a), 64'd0);
    end else begin
      ev = mq.size() > (m_inflight ? 1 : 0);
      hs = ev && ready_a;
      er = !redirect_a && (mq.size() < DEPTH + (hs ? 1 : 0));
      check_output("imem_req",  64'(req_a),   64'(er));
      check_output("imem_addr", 64'(addr_a),  64'(m_pc));
      check_output("out_valid", 64'(valid_a), 64'(ev));
      if (ev) begin
        check_output("out_pc",      64'(pc_a),    64'(mq[0]));
        check_output("out_pc_next", 64'(pcn_a),   64'(AW'(mq[0] + 16'd1)));
        check_output("out_instr",   64'(instr_a), 64'(mq[0] ^ 16'h00A5));
      end
      if (valid_a && ready_a) consumed.push_back(pc_a);
      if (redirect_a) begin
        mq.delete();
        m_pc       = rpc_a;
        m_inflight = 1'b0;
      end else begin
        if (hs) void'(mq.pop_front());
        if (er) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 16'd1;
        end
        m_inflight = er;
      end
      if (valid_b && b_pc.size() < 3) begin
        b_pc.push_back(pc_b);
        b_pcn.push_back(pcn_b);
        b_instr.push_back(instr_b);
      end
    end
  end

  initial begin
    int mark;
    int hits;
    int idx;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("c0_imem_req",  64'(req_a),  64'd1);
    check_output("c0_imem_addr", 64'(addr_a), 64'h100);
    @(negedge clk);
    check_output("c1_imem_addr", 64'(addr_a),  64'h101);
    check_output("c1_out_valid", 64'(valid_a), 64'd0);
    @(negedge clk);
    check_output("c2_imem_addr",   64'(addr_a),  64'h102);
    check_output("c2_out_valid",   64'(valid_a), 64'd1);
    check_output("c2_out_pc",      64'(pc_a),    64'h100);
    check_output("c2_out_pc_next", 64'(pcn_a),   64'h101);
    check_output("c2_out_instr",   64'(instr_a), 64'h01A5);
    repeat (3) apply_stimulus(1'b0, '0, 1'b1);

    // Decode stalls for five cycles
    repeat (5) apply_stimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    check_output("stall_imem_req",  64'(req_a),   64'd0);
    check_output("stall_out_valid", 64'(valid_a), 64'd1);
    repeat (6) apply_stimulus(1'b0, '0, 1'b1);

    // Redirect with one word in the FIFO and one in flight
    apply_stimulus(1'b1, 16'h0040, 1'b0);
    mark = consumed.size();
    for (int i = 0; i < mark; i++) begin
      check_output("seq_out_pc", 64'(consumed[i]), 64'(16'h0100 + 16'(i)));
    end
    apply_stimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    check_output("rd_out_valid", 64'(valid_a), 64'd0);
    check_output("rd_imem_req",  64'(req_a),   64'd1);
    check_output("rd_imem_addr", 64'(addr_a),  64'h40);
    repeat (4) apply_stimulus(1'b0, '0, 1'b1);
    if (consumed.size() > mark) begin
      check_output("rd_first_pc", 64'(consumed[mark]), 64'h40);
    end else begin
      check_output("rd_first_pc_timeout", 64'(consumed.size()), 64'(mark + 1));
    end

    // Redirect in the same cycle that 0x10 is handed to decode
    apply_stimulus(1'b1, 16'h0010, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 16'h0080, 1'b1);
    @(negedge clk);
    check_output("hs_out_valid", 64'(valid_a), 64'd1);
    check_output("hs_out_pc",    64'(pc_a),    64'h10);
    repeat (6) apply_stimulus(1'b0, '0, 1'b1);
    hits = 0;
    idx  = -1;
    foreach (consumed[i]) begin
      if (consumed[i] == 16'h0010) begin
        hits++;
        idx = i;
      end
    end
    check_output("hs_consumed_once", 64'(hits), 64'd1);
    if (idx >= 0 && idx + 1 < consumed.size()) begin
      check_output("hs_next_pc", 64'(consumed[idx+1]), 64'h80);
    end else begin
      check_output("hs_next_pc_missing", 64'(consumed.size()), 64'(idx + 2));
    end

    // Asynchronous reset with a request in flight
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("arst_out_valid",   64'(valid_a), 64'd0);
    check_output("arst_imem_req",    64'(req_a),   64'd0);
    check_output("arst_out_pc",      64'(pc_a),    64'd0);
    check_output("arst_out_pc_next", 64'(pcn_a),   64'd0);
    check_output("arst_out_instr",   64'(instr_a), 64'd0);
    #1 rst = 1'b1;
    mark = consumed.size();
    @(negedge clk);
    check_output("arst_restart_addr", 64'(addr_a), 64'h100);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = consumed.size() > mark;
    end
    if (seen) begin
      check_output("arst_first_pc", 64'(consumed[mark]), 64'h100);
    end else begin
      check_output("arst_first_pc_timeout", 64'(consumed.size()), 64'(mark + 1));
    end

    // PC wrap on the 8-bit instance
    if (b_pc.size() == 3) begin
      check_output("wrap_pc0",     64'(b_pc[0]),    64'hFE);
      check_output("wrap_pc1",     64'(b_pc[1]),    64'hFF);
      check_output("wrap_pc2",     64'(b_pc[2]),    64'h00);
      check_output("wrap_pcn1",    64'(b_pcn[1]),   64'h00);
      check_output("wrap_instr0",  64'(b_instr[0]), 64'h5B);
    end else begin
      check_output("wrap_capture_count", 64'(b_pc.size()), 64'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
